// File: rtl/toy_bpu_redirect_ctrl.sv
// toy_bpu_redirect_ctrl
// Arbitrates frontend redirects between the backend commit stage, the execute
// stage and the bp2 predictor. A backend/execute redirect flushes the fetch
// pipeline for one cycle and then stalls bp1 for RESTART_CYC cycles. A bp2
// flow change only reloads the bp1 PC, and only while no flush sequence runs.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   be_redirect_vld/pc                backend redirect (highest priority)
//   ex_redirect_vld/pc                execute redirect
//   bpdec_bp2_vld/chgflw/tgt_pc       bp2 flow override (lowest priority)
//   fe_ctrl_flush                     flush pulse to BTFIFO / fetch pipeline
//   bp1_redirect_vld/pc               bp1 PC reload strobe and target
//   bp1_stall                         bp1 must not issue predictions
//   flush_cnt                         saturating count of flush cycles
module toy_bpu_redirect_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned RESTART_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  be_redirect_vld,
   input  logic [ADDR_WIDTH-1:0] be_redirect_pc,
   input  logic                  ex_redirect_vld,
   input  logic [ADDR_WIDTH-1:0] ex_redirect_pc,
   input  logic                  bpdec_bp2_vld,
   input  logic                  bpdec_bp2_chgflw,
   input  logic [ADDR_WIDTH-1:0] bpdec_bp2_tgt_pc,
   output logic                  fe_ctrl_flush,
   output logic                  bp1_redirect_vld,
   output logic [ADDR_WIDTH-1:0] bp1_redirect_pc,
   output logic                  bp1_stall,
   output logic [15:0]           flush_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_RESTART
   } state_e;

   localparam logic [3:0] RESTART_LD = 4'(RESTART_CYC);

   state_e                  state_q, state_d;
   logic [3:0]              rst_cnt_q, rst_cnt_d;
   logic                    fe_ctrl_flush_q, fe_ctrl_flush_d;
   logic                    bp1_redirect_vld_q, bp1_redirect_vld_d;
   logic [ADDR_WIDTH-1:0]   bp1_redirect_pc_q, bp1_redirect_pc_d;
   logic                    bp1_stall_q, bp1_stall_d;
   logic [15:0]             flush_cnt_q, flush_cnt_d;

   logic                    flush_req;
   logic                    bp2_redir;

   always_comb begin
      state_d            = state_q;
      rst_cnt_d          = rst_cnt_q;
      bp1_redirect_pc_d  = bp1_redirect_pc_q;
      bp1_redirect_vld_d = 1'b0;
      flush_cnt_d        = flush_cnt_q;

      flush_req = be_redirect_vld | ex_redirect_vld;
      bp2_redir = bpdec_bp2_vld & bpdec_bp2_chgflw & ~flush_req;

      if (flush_req) begin
         // A new flush wins in any state and restarts the whole sequence.
         state_d           = S_FLUSH;
         rst_cnt_d         = RESTART_LD;
         bp1_redirect_pc_d = be_redirect_vld ? be_redirect_pc : ex_redirect_pc;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bp2_redir) begin
                  bp1_redirect_vld_d = 1'b1;
                  bp1_redirect_pc_d  = bpdec_bp2_tgt_pc;
               end
            end
            S_FLUSH: begin
               if (RESTART_CYC == 0) begin
                  state_d   = S_IDLE;
                  rst_cnt_d = '0;
               end else begin
                  state_d   = S_RESTART;
                  rst_cnt_d = RESTART_LD;
               end
            end
            S_RESTART: begin
               if (rst_cnt_q <= 4'd1) begin
                  state_d   = S_IDLE;
                  rst_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q - 4'd1;
               end
            end
            default: begin
               state_d   = S_IDLE;
               rst_cnt_d = '0;
            end
         endcase
      end

      // Outputs are registered copies of the next-state decode.
      fe_ctrl_flush_d    = (state_d == S_FLUSH);
      bp1_redirect_vld_d = bp1_redirect_vld_d | fe_ctrl_flush_d;
      bp1_stall_d        = (state_d != S_IDLE);
      if (fe_ctrl_flush_d && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= S_IDLE;
         rst_cnt_q          <= '0;
         fe_ctrl_flush_q    <= 1'b0;
         bp1_redirect_vld_q <= 1'b0;
         bp1_redirect_pc_q  <= '0;
         bp1_stall_q        <= 1'b0;
         flush_cnt_q        <= '0;
      end else begin
         state_q            <= state_d;
         rst_cnt_q          <= rst_cnt_d;
         fe_ctrl_flush_q    <= fe_ctrl_flush_d;
         bp1_redirect_vld_q <= bp1_redirect_vld_d;
         bp1_redirect_pc_q  <= bp1_redirect_pc_d;
         bp1_stall_q        <= bp1_stall_d;
         flush_cnt_q        <= flush_cnt_d;
      end
   end

   assign fe_ctrl_flush    = fe_ctrl_flush_q;
   assign bp1_redirect_vld = bp1_redirect_vld_q;
   assign bp1_redirect_pc  = bp1_redirect_pc_q;
   assign bp1_stall        = bp1_stall_q;
   assign flush_cnt        = flush_cnt_q;

endmodule

// File: tb/tb_toy_bpu_redirect_ctrl.sv
// Self-checking bench for toy_bpu_redirect_ctrl: a directed vector table,
// hand-written async-reset and counter-saturation sequences, and randomized
// traffic compared against a cycle-age reference model.
module tb_toy_bpu_redirect_ctrl;

   localparam int AW = 32;
   localparam int RC = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          be_vld, ex_vld, bp2_vld, bp2_chg;
   logic [AW-1:0] be_pc, ex_pc, bp2_tgt;
   logic          flush, rd_vld, stall;
   logic [AW-1:0] rd_pc;
   logic [15:0]   fcnt;

   int n_checks = 0;
   int n_errors = 0;

   toy_bpu_redirect_ctrl #(.ADDR_WIDTH(AW), .RESTART_CYC(RC)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .be_redirect_vld  (be_vld),
      .be_redirect_pc   (be_pc),
      .ex_redirect_vld  (ex_vld),
      .ex_redirect_pc   (ex_pc),
      .bpdec_bp2_vld    (bp2_vld),
      .bpdec_bp2_chgflw (bp2_chg),
      .bpdec_bp2_tgt_pc (bp2_tgt),
      .fe_ctrl_flush    (flush),
      .bp1_redirect_vld (rd_vld),
      .bp1_redirect_pc  (rd_pc),
      .bp1_stall        (stall),
      .flush_cnt        (fcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          be;
      logic [AW-1:0] bepc;
      logic          ex;
      logic [AW-1:0] expc;
      logic          bv;
      logic          bc;
      logic [AW-1:0] tgt;
      logic          e_flush;
      logic          e_vld;
      logic [AW-1:0] e_pc;
      logic          e_stall;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t mkv(logic be, logic [AW-1:0] bepc, logic ex, logic [AW-1:0] expc,
                                logic bv, logic bc, logic [AW-1:0] tgt,
                                logic ef, logic ev, logic [AW-1:0] epc, logic es);
      vec_t v;
      v.be = be; v.bepc = bepc; v.ex = ex; v.expc = expc;
      v.bv = bv; v.bc = bc; v.tgt = tgt;
      v.e_flush = ef; v.e_vld = ev; v.e_pc = epc; v.e_stall = es;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic be, input logic [AW-1:0] bepc, input logic ex,
                        input logic [AW-1:0] expc, input logic bv, input logic bc,
                        input logic [AW-1:0] tgt);
      be_vld = be; be_pc = bepc; ex_vld = ex; ex_pc = expc;
      bp2_vld = bv; bp2_chg = bc; bp2_tgt = tgt;
   endtask

   task automatic idle_in();
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   // Sample 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Reference model: age counts cycles since the last FLUSH cycle
   // (0 = FLUSH cycle, 1..RC = restart stall, >RC = idle).
   int          m_age;
   logic [31:0] m_pc;
   logic [15:0] m_cnt;
   logic        m_vld;

   task automatic model_reset();
      m_age = RC + 1; m_pc = '0; m_cnt = '0; m_vld = 1'b0;
   endtask

   task automatic model_step();
      logic was_idle;
      was_idle = (m_age > RC);
      m_vld = 1'b0;
      if (be_vld || ex_vld) begin
         m_age = 0;
         m_pc  = be_vld ? be_pc : ex_pc;
         m_vld = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
         if (was_idle && bp2_vld && bp2_chg) begin
            m_vld = 1'b1;
            m_pc  = bp2_tgt;
         end
         if (m_age <= RC) m_age++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      #3;
      check("reset_flush", {31'd0, flush}, 32'd0);
      check("reset_vld",   {31'd0, rd_vld}, 32'd0);
      check("reset_pc",    rd_pc, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_cnt",   {16'd0, fcnt}, 32'd0);
      do_reset();

      // Directed table, starting from IDLE after reset.
      tbl[0]  = mkv(1, 32'h1000, 0, 0,        0, 0, 0,        1, 1, 32'h1000, 1);
      tbl[1]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h1000, 1);
      tbl[2]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h1000, 1);
      tbl[3]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h1000, 0);
      tbl[4]  = mkv(1, 32'h2000, 1, 32'h3000, 1, 1, 32'h4000, 1, 1, 32'h2000, 1);
      tbl[5]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h2000, 1);
      tbl[6]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h2000, 1);
      tbl[7]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h2000, 0);
      tbl[8]  = mkv(0, 0,        0, 0,        1, 1, 32'h5000, 0, 1, 32'h5000, 0);
      tbl[9]  = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h5000, 0);
      tbl[10] = mkv(0, 0,        0, 0,        1, 0, 32'h7000, 0, 0, 32'h5000, 0);
      tbl[11] = mkv(0, 0,        1, 32'h6000, 0, 0, 0,        1, 1, 32'h6000, 1);
      tbl[12] = mkv(0, 0,        0, 0,        1, 1, 32'h8000, 0, 0, 32'h6000, 1);
      tbl[13] = mkv(0, 0,        0, 0,        1, 1, 32'h8000, 0, 0, 32'h6000, 1);
      tbl[14] = mkv(0, 0,        1, 32'h6100, 0, 0, 0,        1, 1, 32'h6100, 1);
      tbl[15] = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h6100, 1);
      tbl[16] = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h6100, 1);
      tbl[17] = mkv(0, 0,        0, 0,        0, 0, 0,        0, 0, 32'h6100, 0);
      tbl[18] = mkv(1, 32'hA000, 1, 32'h9000, 0, 0, 0,        1, 1, 32'hA000, 1);

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].be, tbl[i].bepc, tbl[i].ex, tbl[i].expc, tbl[i].bv, tbl[i].bc, tbl[i].tgt);
         step();
         check($sformatf("tbl%0d_flush", i), {31'd0, flush},  {31'd0, tbl[i].e_flush});
         check($sformatf("tbl%0d_vld", i),   {31'd0, rd_vld}, {31'd0, tbl[i].e_vld});
         check($sformatf("tbl%0d_pc", i),    rd_pc,           tbl[i].e_pc);
         check($sformatf("tbl%0d_stall", i), {31'd0, stall},  {31'd0, tbl[i].e_stall});
      end
      check("tbl_flush_cnt", {16'd0, fcnt}, 32'd5);

      // Async reset in the middle of RESTART, then first cycle behaves as IDLE.
      idle_in();
      step();                 // RESTART, one stall cycle remaining after this
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_flush", {31'd0, flush},  32'd0);
      check("areset_vld",   {31'd0, rd_vld}, 32'd0);
      check("areset_pc",    rd_pc,           32'd0);
      check("areset_stall", {31'd0, stall},  32'd0);
      check("areset_cnt",   {16'd0, fcnt},   32'd0);
      step();
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hB000);
      step();
      check("post_reset_bp2_vld",   {31'd0, rd_vld}, 32'd1);
      check("post_reset_bp2_pc",    rd_pc,           32'hB000);
      check("post_reset_bp2_stall", {31'd0, stall},  32'd0);

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 7) == 0), $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
         model_step();
         step();
         check("rnd_flush", {31'd0, flush},  {31'd0, (m_age == 0)});
         check("rnd_vld",   {31'd0, rd_vld}, {31'd0, m_vld});
         check("rnd_pc",    rd_pc,           m_pc);
         check("rnd_stall", {31'd0, stall},  {31'd0, (m_age <= RC)});
         check("rnd_cnt",   {16'd0, fcnt},   {16'd0, m_cnt});
      end

      // Flush counter saturation: back-to-back flushes, one per cycle.
      do_reset();
      drive(1'b1, 32'hC000, 1'b0, '0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 65535; i++) step();
      check("sat_reach", {16'd0, fcnt}, 32'h0000FFFF);
      step();
      check("sat_hold",  {16'd0, fcnt}, 32'h0000FFFF);
      check("sat_flush", {31'd0, flush}, 32'd1);
      idle_in();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
